// File: rtl/buzzer_music_player.sv
// Music sequencer: fetches 12-bit note words from a synchronous ROM and plays
// each one as a square wave on the buzzer for a duration counted in beats.
module buzzer_music_player #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 12,
  parameter int BEAT_CYCLES = 12500000,
  parameter int TONE_DIV    = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  buzzer,
  output logic                  busy,
  output logic                  done
);

  localparam int BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam int TW = $clog2(255 * TONE_DIV);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
  localparam logic [TW-1:0] TDIV      = TW'(TONE_DIV);

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, PLAY, NEXT} state_t;

  state_t          state;
  logic [3:0]      dur;
  logic [7:0]      note;
  logic [BW-1:0]   beat_cnt;
  logic [3:0]      beat_num;
  logic [TW-1:0]   tone_cnt;
  logic [TW-1:0]   half_m1;

  // Unused for rests (note=0), where the tone counter is frozen.
  assign half_m1 = TW'(note) * TDIV - TW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rom_en   <= 1'b0;
      rom_addr <= '0;
      buzzer   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dur      <= '0;
      note     <= '0;
      beat_cnt <= '0;
      beat_num <= '0;
      tone_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (stop && state != IDLE) begin
        state    <= IDLE;
        rom_en   <= 1'b0;
        rom_addr <= '0;
        buzzer   <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // busy drops one cycle after the done pulse
            buzzer <= 1'b0;
            rom_en <= 1'b0;
            busy   <= 1'b0;
            if (start && !stop) begin
              state    <= FETCH;
              rom_addr <= '0;
              rom_en   <= 1'b1;
              busy     <= 1'b1;
            end
          end
          FETCH: begin
            rom_en <= 1'b0;
            state  <= LATCH;
          end
          LATCH: begin
            dur  <= rom_data[11:8];
            note <= rom_data[7:0];
            if (rom_data[11:8] == 4'd0) begin
              if (loop_en) begin
                rom_addr <= '0;
                rom_en   <= 1'b1;
                state    <= FETCH;
              end else begin
                done  <= 1'b1;
                state <= IDLE;
              end
            end else begin
              beat_cnt <= '0;
              beat_num <= 4'd1;
              tone_cnt <= '0;
              buzzer   <= 1'b0;
              state    <= PLAY;
            end
          end
          PLAY: begin
            if (note != 8'd0) begin
              if (tone_cnt == half_m1) begin
                tone_cnt <= '0;
                buzzer   <= ~buzzer;
              end else begin
                tone_cnt <= tone_cnt + TW'(1);
              end
            end
            if (beat_cnt == BEAT_LAST) begin
              beat_cnt <= '0;
              if (beat_num == dur) begin
                buzzer <= 1'b0;
                state  <= NEXT;
              end else begin
                beat_num <= beat_num + 4'd1;
              end
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
          NEXT: begin
            buzzer <= 1'b0;
            // Last ROM word played without a marker ends the song like one.
            if (&rom_addr) begin
              if (loop_en) begin
                rom_addr <= '0;
                rom_en   <= 1'b1;
                state    <= FETCH;
              end else begin
                done  <= 1'b1;
                state <= IDLE;
              end
            end else begin
              rom_addr <= rom_addr + ADDR_WIDTH'(1);
              rom_en   <= 1'b1;
              state    <= FETCH;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_buzzer_music_player.sv
// Bench for buzzer_music_player: event-level timing model feeds a scoreboard
// queue; a negedge monitor pops and compares every observed output event.
module tb_buzzer_music_player;
  localparam int AW = 2, BEAT = 20, TDIV = 2;

  logic          clk = 1'b0, rst, start, stop, loop_en;
  logic          rom_en, buzzer, busy, done;
  logic [AW-1:0] rom_addr;
  logic [11:0]   rom_data;
  logic [11:0]   rom [4];

  int n_pass = 0, n_tot = 0, cyc = 0;

  // kind: 0 fetch (val=addr), 1 buzzer level, 2 done, 3 busy level
  typedef struct {int kind; int t; int val;} ev_t;
  ev_t exp_q[$];
  int  dec_t[$];
  bit   mon_en = 1'b0;
  logic prev_buz = 1'b0, prev_busy = 1'b0;

  buzzer_music_player #(.ADDR_WIDTH(AW), .DATA_WIDTH(12), .BEAT_CYCLES(BEAT), .TONE_DIV(TDIV)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .buzzer(buzzer), .busy(busy), .done(done));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rom_en) rom_data <= rom[rom_addr];
  end

  task automatic chk(input string nm, input int act, input int req);
    n_tot++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
  endtask

  task automatic obs(input int k, input int v);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event_kind", k, -1);
      return;
    end
    e = exp_q.pop_front();
    chk("ev_kind", k, e.kind);
    chk("ev_time", cyc, e.t);
    chk("ev_val", v, e.val);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rom_en) obs(0, int'(rom_addr));
      if (buzzer !== prev_buz) obs(1, int'(buzzer));
      if (done) obs(2, 0);
      if (busy !== prev_busy) obs(3, int'(busy));
    end
    prev_buz  <= buzzer;
    prev_busy <= busy;
  end

  function automatic void push(input int k, input int t, input int v);
    ev_t e;
    int  i;
    e = '{k, t, v};
    i = exp_q.size();
    while (i > 0 && (exp_q[i-1].t > t || (exp_q[i-1].t == t && exp_q[i-1].kind > k))) i--;
    exp_q.insert(i, e);
  endfunction

  // Song timeline from start cycle S: fetch at f, data at f+1, play f+2..f+1+P,
  // decision cycle c, its consequence (fetch or done) at c+1.
  task automatic build(input int s, input int passes);
    int f, addr, d, nt, h, p, lvl, c, ndec;
    bit fin;
    exp_q.delete();
    dec_t.delete();
    push(3, s, 1);
    f = s; addr = 0; ndec = 0; fin = 0;
    while (!fin) begin
      push(0, f, addr);
      d  = int'(rom[addr][11:8]);
      nt = int'(rom[addr][7:0]);
      if (d == 0) c = f + 1;
      else begin
        p = d * BEAT; h = nt * TDIV; lvl = 0;
        if (nt != 0)
          for (int t = f + 2 + h; t < f + 2 + p; t += h) begin
            lvl ^= 1;
            push(1, t, lvl);
          end
        if (lvl != 0) push(1, f + 2 + p, 0);
        c = f + 2 + p;
      end
      if (d == 0 || addr == 3) begin
        ndec++;
        dec_t.push_back(c);
        if (ndec < passes) begin addr = 0; f = c + 1; end
        else begin push(2, c + 1, 0); push(3, c + 2, 0); fin = 1; end
      end else begin
        addr++;
        f = c + 1;
      end
    end
  endtask

  task automatic run(input int passes, input bit glitch);
    int bud;
    @(negedge clk);
    build(cyc + 1, passes);
    loop_en = (passes > 1);
    start   = 1'b1;
    mon_en  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bud = 0;
    while (exp_q.size() > 0 && bud < 3000) begin
      @(negedge clk);
      bud++;
      if (passes > 1 && loop_en && cyc == dec_t[passes-2] + 1) loop_en = 1'b0;
      start = (glitch && bud == 5);
    end
    start = 1'b0;
    chk("events_missing", exp_q.size(), 0);
    repeat (30) @(negedge clk);
    chk("busy_after_song", int'(busy), 0);
    mon_en = 1'b0;
  endtask

  initial begin
    int  s;
    bit  bad;
    int  n;
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    for (int a = 0; a < 4; a++) rom[a] = 12'h000;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_buzzer", int'(buzzer), 0);
    chk("rst_rom_en", int'(rom_en), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // basic note, rest, loop x3, address wrap
    rom[0] = 12'h305; rom[1] = 12'h000; run(1, 0);
    rom[0] = 12'h200; run(1, 0);
    rom[0] = 12'h101; run(3, 0);
    for (int a = 0; a < 4; a++) rom[a] = 12'h101;
    run(1, 0);
    run(2, 1);

    // stop mid-note, then start held off by stop
    rom[0] = 12'h302; rom[1] = 12'h000;
    @(negedge clk); start = 1'b1; s = cyc + 1;
    @(negedge clk); start = 1'b0;
    while (cyc < s + 8) @(negedge clk);
    chk("pre_stop_buzzer", int'(buzzer), 1);
    stop = 1'b1;
    @(negedge clk);
    chk("stop_busy", int'(busy), 0);
    chk("stop_buzzer", int'(buzzer), 0);
    chk("stop_rom_addr", int'(rom_addr), 0);
    chk("stop_rom_en", int'(rom_en), 0);
    chk("stop_done", int'(done), 0);
    start = 1'b1; bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || done || rom_en) bad = 1;
    end
    chk("stop_holds_idle", int'(bad), 0);
    start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);

    // asynchronous reset mid-PLAY
    rom[0] = 12'h305;
    @(negedge clk); start = 1'b1; s = cyc + 1;
    @(negedge clk); start = 1'b0;
    while (cyc < s + 14) @(negedge clk);
    chk("pre_rst_buzzer", int'(buzzer), 1);
    chk("pre_rst_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_buzzer", int'(buzzer), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_rom_addr", int'(rom_addr), 0);
    chk("arst_done", int'(done), 0);
    @(negedge clk); rst = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || done || buzzer) bad = 1;
    end
    chk("post_rst_idle", int'(bad), 0);

    // randomized songs with an ignored start pulse during playback
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 4));
      for (int a = 0; a < 4; a++)
        rom[a] = (a < n) ? {4'($urandom_range(1, 3)), 8'($urandom_range(0, 5))} : 12'h000;
      run(int'($urandom_range(1, 3)), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/buzzer_music_player.md
Name: buzzer_music_player

Overview:
Sequencer that walks the music block ROM and turns each 12-bit note word into a square wave on the buzzer pin. It drives the ROM enable and address, then consumes the synchronous read data, which is valid one cycle after the enable. Each word is played for a duration counted in beats. The block sits between the game-event logic (start/stop) and the buzzer output pin.

Parameters:
ADDR_WIDTH, 16, ROM address width; must match the ROM.
DATA_WIDTH, 12, ROM word width; fixed at 12 for the word format below.
BEAT_CYCLES, 12500000, clk cycles per beat (125 ms at 100 MHz).
TONE_DIV, 1000, clk cycles per half-period unit (10 us at 100 MHz).

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous reset, active-high.
start  in  1  level; sampled in IDLE only; begins playback at address 0.
stop  in  1  level; aborts playback from any state.
loop_en  in  1  on end marker: 1 = restart at address 0, 0 = finish.
rom_en  out  1  ROM read enable.
rom_addr  out  ADDR_WIDTH  ROM read address.
rom_data  in  DATA_WIDTH  ROM read data, valid the cycle after rom_en=1.
buzzer  out  1  square-wave output.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when a song ends without looping.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all outputs 0, rom_addr=0, state IDLE, all counters 0.
- Word format: dur=rom_data[11:8] in beats, note=rom_data[7:0].
  - dur=0 is the end marker.
  - note=0 is a rest: buzzer held 0 for the duration.
  - Otherwise half-period = note*TONE_DIV cycles.
- FSM states: IDLE, FETCH, LATCH, PLAY, NEXT.
- IDLE: buzzer=0. On start=1 and stop=0, go to FETCH with rom_addr=0.
- FETCH: rom_en=1 for exactly this one cycle, then go to LATCH.
- LATCH: register dur/note from rom_data; rom_en=0.
  - If dur=0 and loop_en=1: rom_addr<=0, go to FETCH.
  - If dur=0 and loop_en=0: done=1 for one cycle, go to IDLE.
  - Otherwise: clear the beat and tone counters, buzzer<=0, go to PLAY.
- PLAY: occupies exactly dur*BEAT_CYCLES cycles.
  - Tone counter counts 0..note*TONE_DIV-1; buzzer toggles on wrap.
  - The first toggle occurs note*TONE_DIV cycles after PLAY entry.
  - Beat counter counts 0..BEAT_CYCLES-1 and a beat counter 1..dur tracks the beats played.
  - After the last cycle of the last beat, go to NEXT.
- NEXT: buzzer<=0.
  - If rom_addr = 2^ADDR_WIDTH-1: treat as end marker (done pulse or loop as above, using the current loop_en).
  - Otherwise rom_addr<=rom_addr+1, go to FETCH.
- Per-note overhead: FETCH+LATCH+NEXT = 3 cycles between consecutive PLAY states.
- stop=1 in any non-IDLE state: next cycle state=IDLE, buzzer=0, rom_en=0, rom_addr=0, no done pulse. stop has priority over start and over every other transition.
- start while busy is ignored. loop_en is sampled only at the end decision.
- rst mid-playback: immediately returns to reset values; no done pulse.
- Counter widths:
  - beat counter: clog2(BEAT_CYCLES).
  - tone counter: clog2(255*TONE_DIV).
  - no overflow is permitted for legal parameters.

Test Plan:
(All scenarios use BEAT_CYCLES=20, TONE_DIV=2 and a ROM model with 1-cycle read latency.)
- Basic note: ROM[0]=0x305, ROM[1]=0x000; pulse start; loop_en=0.
  -> rom_en high 1 cycle at addr 0.
  -> buzzer toggles every 10 cycles for 60 cycles (3 full periods).
  -> fetch at addr 1, then a single done pulse; busy falls the cycle after done.
- Rest: ROM[0]=0x200, ROM[1]=0x000.
  -> buzzer stays 0 for 40 cycles; done pulses; total start-to-done latency is 1+1+40+1+1+1 cycles.
- Loop: ROM[0]=0x101, ROM[1]=0x000, loop_en=1.
  -> after the end marker, rom_addr returns to 0 and playback repeats 3 times with no done pulse.
  -> clearing loop_en during the 3rd pass yields done at that pass's end.
- Stop mid-note: assert stop 7 cycles into PLAY.
  -> next cycle: busy=0, buzzer=0, rom_addr=0, no done.
  -> start with stop=1 held keeps the block in IDLE.
- Async reset: assert rst mid-PLAY between clock edges.
  -> outputs go to 0 before the next edge.
  -> a start pulse during PLAY (without reset) is ignored and playback timing is unchanged.
- Address wrap: ADDR_WIDTH=2, ROM[0..3]=0x101 (no marker), loop_en=0.
  -> four notes play, then done after addr 3 with no fetch of addr 0.
